// File: rtl/rv32i_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, decode handshake and branch redirect.
// The master modport is the fetch stage; the slave modport is memory, decode and branch logic together.
interface rv32i_fetch_stage_if #(
    parameter int WORD_SIZE         = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         o_imem_req;
    logic [WORD_SIZE-1:0]         o_imem_addr;
    logic                         i_imem_ready;
    logic                         i_imem_rvalid;
    logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata;
    logic                         o_fetch_valid_send;
    logic                         i_decode_ready_recv;
    logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction;
    logic [WORD_SIZE-1:0]         o_fetch_instruction_pc;
    logic                         i_branch_redirect;
    logic [WORD_SIZE-1:0]         i_branch_target;
    logic                         o_fetch_misaligned;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output o_fetch_valid_send,
        input  i_decode_ready_recv,
        output o_fetch_instruction, o_fetch_instruction_pc,
        input  i_branch_redirect, i_branch_target,
        output o_fetch_misaligned
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  o_fetch_valid_send,
        output i_decode_ready_recv,
        input  o_fetch_instruction, o_fetch_instruction_pc,
        output i_branch_redirect, i_branch_target,
        input  o_fetch_misaligned
    );
endinterface

// File: rtl/rv32i_fetch_stage.sv
// RV32I fetch stage: owns the PC, keeps one imem read in flight, and hands instructions to decode.
// Optional macro RV32I_FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into a sticky halt.
module rv32i_fetch_stage #(
    parameter int                   WORD_SIZE         = 32,
    parameter int                   INSTRUCTION_WIDTH = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC          = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rv32i_fetch_stage_if.master  bus
);

    typedef enum logic [1:0] {
        FetchIdle,
        FetchRequest,
        FetchWait,
        FetchHold
    } fetch_state_e;

    fetch_state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]         pc_q, pc_d;
    logic [WORD_SIZE-1:0]         instr_pc_q, instr_pc_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic                         drop_q, drop_d;
    logic                         valid_q, valid_d;
    logic                         imem_req;
    logic                         handshake;
    logic                         redirect;
    logic [WORD_SIZE-1:0]         target;
    logic                         misaligned_set;
    logic                         trapped;

    assign redirect = bus.i_branch_redirect;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign target         = bus.i_branch_target;
    assign misaligned_set = redirect && (target[1:0] != 2'b00);
    assign trapped        = misaligned_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)               misaligned_q <= 1'b0;
        else if (misaligned_set) misaligned_q <= 1'b1;
    end

    assign bus.o_fetch_misaligned = misaligned_q;
`else
    // Without the trap, low target bits are simply ignored so the PC stays word aligned.
    assign target                 = bus.i_branch_target & ~WORD_SIZE'(3);
    assign misaligned_set         = 1'b0;
    assign trapped                = 1'b0;
    assign bus.o_fetch_misaligned = 1'b0;
`endif

    // A redirect cycle never transfers: the held word may be from the wrong path.
    assign bus.o_fetch_valid_send = valid_q & ~redirect;
    assign handshake              = bus.o_fetch_valid_send & bus.i_decode_ready_recv;

    always_comb begin
        // NOTE: every signal gets its hold value before the case, so no path infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        imem_req   = 1'b0;

        case (state_q)
            FetchIdle: begin
                if (!trapped) state_d = FetchRequest;
            end
            FetchRequest: begin
                imem_req = ~redirect;
                if (imem_req && bus.i_imem_ready) state_d = FetchWait;
            end
            FetchWait: begin
                if (bus.i_imem_rvalid) begin
                    if (!drop_q && !redirect) begin
                        instr_d    = bus.i_imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = FetchHold;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = FetchRequest;
                    end
                end else if (redirect) begin
                    // The in-flight response still has to be absorbed; mark it for discard.
                    drop_d = 1'b1;
                end
            end
            FetchHold: begin
                if (handshake) begin
                    pc_d    = pc_q + WORD_SIZE'(4);
                    valid_d = 1'b0;
                    state_d = FetchRequest;
                end
            end
            default: state_d = FetchIdle;
        endcase

        // Redirect overrides whatever the state logic chose for the PC and the held word.
        if (redirect) begin
            pc_d = target;
            if (state_q == FetchHold) begin
                valid_d = 1'b0;
                state_d = FetchRequest;
            end
        end

        if (misaligned_set) begin
            valid_d = 1'b0;
            drop_d  = 1'b0;
            state_d = FetchIdle;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= FetchIdle;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register here samples the same pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign bus.o_imem_req             = imem_req;
    assign bus.o_imem_addr            = pc_q;
    assign bus.o_fetch_instruction    = instr_q;
    assign bus.o_fetch_instruction_pc = instr_pc_q;

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Directed bench for rv32i_fetch_stage: behavioural imem with programmable latency plus a
// transfer monitor; each scenario task checks its own hand-computed expectations.
module tb_rv32i_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rv32i_fetch_stage_if bus ();

    rv32i_fetch_stage dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Memory latency L: rvalid is high in the L-th cycle after the accepting edge.
    int          mem_lat = 2;
    int          mem_cnt = 0;
    logic [31:0] mem_pending = '0;
    int          cyc = 0;

    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] xfer_pc_q[$];
    logic [31:0] xfer_ins_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Monitor and memory: sample handshakes at the edge, drive the response 1 ns later.
    always @(posedge clk) begin
        logic        accepted;
        logic [31:0] acc_addr;
        accepted = !rst && bus.o_imem_req && bus.i_imem_ready;
        acc_addr = bus.o_imem_addr;
        if (!rst) begin
            if (accepted) begin
                req_addr_q.push_back(acc_addr);
                req_cyc_q.push_back(cyc);
            end
            if (bus.o_fetch_valid_send && bus.i_decode_ready_recv) begin
                xfer_pc_q.push_back(bus.o_fetch_instruction_pc);
                xfer_ins_q.push_back(bus.o_fetch_instruction);
            end
        end
        cyc++;
        #1;
        bus.i_imem_rvalid = 1'b0;
        if (rst) begin
            mem_cnt = 0;
        end else begin
            if (accepted) begin
                mem_cnt     = mem_lat;
                mem_pending = mem_word(acc_addr);
            end
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.i_imem_rvalid = 1'b1;
                    bus.i_imem_rdata  = mem_pending;
                end
            end
        end
    end

    task automatic clear_logs();
        req_addr_q.delete();
        req_cyc_q.delete();
        xfer_pc_q.delete();
        xfer_ins_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                     = 1'b1;
        bus.i_branch_redirect   = 1'b0;
        bus.i_branch_target     = '0;
        bus.i_imem_ready        = 1'b1;
        bus.i_decode_ready_recv = 1'b1;
        mem_lat                 = 2;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget, input string tag);
        int k = 0;
        while (req_addr_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (req_addr_q.size() < n) begin
            miscompares++;
            $display("FAIL %s: %0d requests seen, %0d required", tag, req_addr_q.size(), n);
        end
    endtask

    task automatic wait_xfers(input int n, input int budget, input string tag);
        int k = 0;
        while (xfer_pc_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (xfer_pc_q.size() < n) begin
            miscompares++;
            $display("FAIL %s: %0d transfers seen, %0d required", tag, xfer_pc_q.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.i_branch_redirect   = 1'b0;
        bus.i_branch_target     = '0;
        bus.i_imem_ready        = 1'b1;
        bus.i_decode_ready_recv = 1'b1;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.o_imem_req, bus.o_fetch_valid_send, bus.o_fetch_misaligned} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 000",
                     {bus.o_imem_req, bus.o_fetch_valid_send, bus.o_fetch_misaligned});
        end
        vectors++;
        if (bus.o_fetch_instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_instr: got %h required 00000000", bus.o_fetch_instruction);
        end
        vectors++;
        if (bus.o_fetch_instruction_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_instr_pc: got %h required 00000000", bus.o_fetch_instruction_pc);
        end
        vectors++;
        if (bus.o_imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr: got %h required 00000000", bus.o_imem_addr);
        end
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.o_imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: got %b required 0", bus.o_imem_req);
        end
        @(negedge clk);
        vectors++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL first_req: req %b addr %h required 1 00000000", bus.o_imem_req, bus.o_imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc[3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_ins[3] = '{32'h1357_9BDF, 32'h1357_9BDB, 32'h1357_9BD7};
        do_reset();
        wait_xfers(3, 60, "seq_timeout");
        if (xfer_pc_q.size() >= 3 && req_addr_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (req_addr_q[i] !== exp_pc[i]) begin
                    miscompares++;
                    $display("FAIL seq_req_addr[%0d]: got %h required %h", i, req_addr_q[i], exp_pc[i]);
                end
                vectors++;
                if (xfer_pc_q[i] !== exp_pc[i] || xfer_ins_q[i] !== exp_ins[i]) begin
                    miscompares++;
                    $display("FAIL seq_xfer[%0d]: got pc %h ins %h required pc %h ins %h",
                             i, xfer_pc_q[i], xfer_ins_q[i], exp_pc[i], exp_ins[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (req_cyc_q[i] - req_cyc_q[i-1] !== 4) begin
                    miscompares++;
                    $display("FAIL seq_cadence[%0d]: got %0d cycles required 4",
                             i, req_cyc_q[i] - req_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int k = 0;
        do_reset();
        bus.i_decode_ready_recv = 1'b0;
        while (!bus.o_fetch_valid_send && k < 30) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus.o_fetch_valid_send !== 1'b1 || bus.o_imem_req !== 1'b0 ||
                bus.o_fetch_instruction !== 32'h1357_9BDF || bus.o_fetch_instruction_pc !== 32'h0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v %b req %b ins %h pc %h required 1 0 13579bdf 00000000",
                         i, bus.o_fetch_valid_send, bus.o_imem_req,
                         bus.o_fetch_instruction, bus.o_fetch_instruction_pc);
            end
            @(negedge clk);
        end
        vectors++;
        if (req_addr_q.size() !== 1) begin
            miscompares++;
            $display("FAIL stall_req_count: got %0d required 1", req_addr_q.size());
        end
        bus.i_decode_ready_recv = 1'b1;
        wait_reqs(2, 10, "stall_release_timeout");
        if (req_addr_q.size() >= 2) begin
            vectors++;
            if (req_addr_q[1] !== 32'h4 || xfer_pc_q.size() !== 1) begin
                miscompares++;
                $display("FAIL stall_release: got addr %h xfers %0d required 00000004 1",
                         req_addr_q[1], xfer_pc_q.size());
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_lat = 3;
        wait_reqs(1, 10, "rw_first_req_timeout");
        bus.i_branch_redirect = 1'b1;
        bus.i_branch_target   = 32'h0000_0100;
        @(negedge clk);
        bus.i_branch_redirect = 1'b0;
        wait_xfers(1, 40, "rw_xfer_timeout");
        if (xfer_pc_q.size() >= 1 && req_addr_q.size() >= 2) begin
            vectors++;
            if (req_addr_q[1] !== 32'h0000_0100) begin
                miscompares++;
                $display("FAIL rw_next_addr: got %h required 00000100", req_addr_q[1]);
            end
            vectors++;
            if (xfer_pc_q[0] !== 32'h0000_0100 || xfer_ins_q[0] !== 32'h1357_9ADF) begin
                miscompares++;
                $display("FAIL rw_xfer: got pc %h ins %h required 00000100 13579adf",
                         xfer_pc_q[0], xfer_ins_q[0]);
            end
        end
    endtask

    task automatic test_redirect_transfer();
        int k = 0;
        do_reset();
        while (!bus.o_fetch_valid_send && k < 30) begin
            @(negedge clk);
            k++;
        end
        bus.i_branch_redirect = 1'b1;
        bus.i_branch_target   = 32'h0000_0200;
        #1;
        vectors++;
        if (bus.o_fetch_valid_send !== 1'b0) begin
            miscompares++;
            $display("FAIL rt_valid_masked: got %b required 0", bus.o_fetch_valid_send);
        end
        @(negedge clk);
        bus.i_branch_redirect = 1'b0;
        #1;
        vectors++;
        if (bus.o_fetch_valid_send !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL rt_refetch: got v %b req %b addr %h required 0 1 00000200",
                     bus.o_fetch_valid_send, bus.o_imem_req, bus.o_imem_addr);
        end
        wait_xfers(1, 20, "rt_xfer_timeout");
        if (xfer_pc_q.size() >= 1) begin
            vectors++;
            if (xfer_pc_q[0] !== 32'h0000_0200 || xfer_ins_q[0] !== 32'h1357_99DF) begin
                miscompares++;
                $display("FAIL rt_xfer: got pc %h ins %h required 00000200 135799df",
                         xfer_pc_q[0], xfer_ins_q[0]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.i_branch_redirect = 1'b1;
        bus.i_branch_target   = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.i_branch_redirect = 1'b0;
        wait_xfers(2, 40, "wrap_timeout");
        if (xfer_pc_q.size() >= 2 && req_addr_q.size() >= 2) begin
            vectors++;
            if (req_addr_q[0] !== 32'hFFFF_FFFC || req_addr_q[1] !== 32'h0) begin
                miscompares++;
                $display("FAIL wrap_addr: got %h %h required fffffffc 00000000", req_addr_q[0], req_addr_q[1]);
            end
            vectors++;
            if (xfer_pc_q[0] !== 32'hFFFF_FFFC || xfer_ins_q[0] !== 32'hECA8_6423 || xfer_pc_q[1] !== 32'h0) begin
                miscompares++;
                $display("FAIL wrap_xfer: got pc %h ins %h pc %h required fffffffc eca86423 00000000",
                         xfer_pc_q[0], xfer_ins_q[0], xfer_pc_q[1]);
            end
        end
    endtask

    task automatic test_misalign();
        do_reset();
        bus.i_imem_ready = 1'b0;
        @(negedge clk);
        bus.i_branch_redirect = 1'b1;
        bus.i_branch_target   = 32'h0000_0102;
        #1;
        vectors++;
        if (bus.o_imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL ma_req_suppressed: got %b required 0", bus.o_imem_req);
        end
        @(negedge clk);
        bus.i_branch_redirect = 1'b0;
        bus.i_imem_ready      = 1'b1;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        repeat (20) @(negedge clk);
        vectors++;
        if (bus.o_fetch_misaligned !== 1'b1 || req_addr_q.size() !== 0 || bus.o_fetch_valid_send !== 1'b0) begin
            miscompares++;
            $display("FAIL ma_trap: got flag %b reqs %0d v %b required 1 0 0",
                     bus.o_fetch_misaligned, req_addr_q.size(), bus.o_fetch_valid_send);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.o_fetch_misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL ma_clear: got %b required 0", bus.o_fetch_misaligned);
        end
        @(negedge clk);
        rst = 1'b0;
`else
        wait_reqs(1, 10, "ma_req_timeout");
        if (req_addr_q.size() >= 1) begin
            vectors++;
            if (req_addr_q[0] !== 32'h0000_0100 || bus.o_fetch_misaligned !== 1'b0) begin
                miscompares++;
                $display("FAIL ma_aligned: got addr %h flag %b required 00000100 0",
                         req_addr_q[0], bus.o_fetch_misaligned);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat = 3;
        wait_reqs(1, 10, "rm_req_timeout");
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rm_async: got req %b addr %h required 0 00000000", bus.o_imem_req, bus.o_imem_addr);
        end
        repeat (2) @(negedge clk);
        clear_logs();
        mem_lat = 2;
        rst     = 1'b0;
        wait_xfers(1, 20, "rm_xfer_timeout");
        if (xfer_pc_q.size() >= 1) begin
            vectors++;
            if (xfer_pc_q[0] !== 32'h0 || xfer_ins_q[0] !== 32'h1357_9BDF) begin
                miscompares++;
                $display("FAIL rm_restart: got pc %h ins %h required 00000000 13579bdf",
                         xfer_pc_q[0], xfer_ins_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_transfer();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
